// File: rtl/fifo_burst_reader.sv
// Show-ahead FIFO drain into a registered valid/ready stream, grouped into bursts with a last flag.
// Optional per-burst statistics ports are enabled by defining FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             iw_clk,
    input  logic             iw_reset_n,
    input  logic [WIDTH-1:0] iwv_fifo_data,
    input  logic             iw_fifo_empty,
    output logic             ow_fifo_rdena,
    output logic [WIDTH-1:0] owv_data,
    output logic             ow_valid,
    output logic             ow_last,
`ifdef FIFO_BURST_READER_STATS_EN
    output logic [15:0]      owv_bursts,
    output logic [15:0]      owv_timeouts,
`endif
    input  logic             iw_ready
);

    localparam int unsigned BiW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned TmrW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BiW-1:0]  BiLast = BiW'(BURST_LEN - 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

    // The hold stage is the FSM: a word is held back until its last flag is known.
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [BiW-1:0]   bi_q, bi_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic hold_v;
    logic out_free;
    logic at_end;
    logic timed_out;
    logic close;
    logic move;
    logic pop;

    always_comb begin
        hold_v    = (state_q == StHold);
        out_free  = !valid_q || iw_ready;
        at_end    = (bi_q == BiLast);
        timed_out = (TIMEOUT != 0) && (timer_q == TmrMax);
        close     = at_end || timed_out;
        move      = hold_v && out_free && (close || !iw_fifo_empty);
        pop       = iw_reset_n && !iw_fifo_empty && (!hold_v || move);
    end

    assign ow_fifo_rdena = pop;
    assign owv_data      = data_q;
    assign ow_valid      = valid_q;
    assign ow_last       = last_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (pop) begin
            state_d = StHold;
            hold_d  = iwv_fifo_data;
        end else if (move) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        bi_d    = bi_q;
        if (move) begin
            valid_d = 1'b1;
            data_d  = hold_q;
            last_d  = close;
            bi_d    = close ? '0 : bi_q + 1'b1;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
    end

    // Counts only while a word waits on an empty FIFO; any arrival or departure restarts it.
    always_comb begin
        timer_d = timer_q;
        if (TIMEOUT == 0 || !hold_v || !iw_fifo_empty || move) begin
            timer_d = '0;
        end else if (timer_q != TmrMax) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_reset_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            bi_q    <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bi_q    <= bi_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0] bursts_q, bursts_d;
    logic [15:0] touts_q, touts_d;

    always_comb begin
        bursts_d = bursts_q;
        touts_d  = touts_q;
        if (valid_q && iw_ready && last_q) begin
            bursts_d = bursts_q + 16'd1;
        end
        // A burst that would have closed on length anyway is not a timeout.
        if (move && timed_out && !at_end) begin
            touts_d = touts_q + 16'd1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_reset_n) begin
            bursts_q <= '0;
            touts_q  <= '0;
        end else begin
            bursts_q <= bursts_d;
            touts_q  <= touts_d;
        end
    end

    assign owv_bursts   = bursts_q;
    assign owv_timeouts = touts_q;
`endif

endmodule
